// File: rtl/pipeline_pkg.sv
// Shared constants and the input width-adaptation helper for pipeline_register.
package pipeline_pkg;

  localparam int DEFAULT_N    = 8;
  localparam int DEFAULT_M    = 8;
  // Widest N or M the resize helper can carry.
  localparam int RESIZE_MAX_W = 64;

  // Zero-extend or truncate: only the low min(n, m) bits of v survive.
  // The caller narrows the result to m bits.
  function automatic logic [RESIZE_MAX_W-1:0] resize(
    input logic [RESIZE_MAX_W-1:0] v,
    input int                      n,
    input int                      m
  );
    logic [RESIZE_MAX_W-1:0] r;
    int keep;
    keep = (n < m) ? n : m;
    r = '0;
    for (int i = 0; i < RESIZE_MAX_W; i++)
      if (i < keep) r[i] = v[i];
    return r;
  endfunction

endpackage

// File: rtl/pipeline_stage.sv
// One M-bit pipeline flop: async reset, synchronous flush, clock enable.
module pipeline_stage
  import pipeline_pkg::*;
#(
  parameter int             W           = DEFAULT_M,
  parameter logic [W-1:0]   RESET_VALUE = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         flush,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Flush outranks enable so a stalled pipe can still be cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       q <= RESET_VALUE;
    else if (flush)  q <= RESET_VALUE;
    else if (enable) q <= d;
  end

endmodule

// File: rtl/pipeline_register.sv
// Clock-enabled, STAGES-deep pipeline register with N->M width adaptation.
// Define PIPELINE_REGISTER_FLUSH_EN to add the synchronous flush input.
module pipeline_register
  import pipeline_pkg::*;
#(
  parameter int           N           = DEFAULT_N,
  parameter int           M           = DEFAULT_M,
  parameter int           STAGES      = 1,
  parameter logic [M-1:0] RESET_VALUE = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
`ifdef PIPELINE_REGISTER_FLUSH_EN
  input  logic         flush,
`endif
  input  logic [N-1:0] in,
  output logic [M-1:0] out
);

  logic                         flush_int;
  logic [RESIZE_MAX_W-1:0]      in_wide;
  logic [M-1:0]                 data0;
  logic [STAGES-1:0][M-1:0]     stage_q;

`ifdef PIPELINE_REGISTER_FLUSH_EN
  assign flush_int = flush;
`else
  assign flush_int = 1'b0;
`endif

  assign in_wide = RESIZE_MAX_W'(in);
  assign data0   = M'(resize(in_wide, N, M));

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [M-1:0] d;
    if (k == 0) begin : g_head
      assign d = data0;
    end else begin : g_tail
      assign d = stage_q[k-1];
    end

    pipeline_stage #(
      .W           (M),
      .RESET_VALUE (RESET_VALUE)
    ) u_stage (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .flush  (flush_int),
      .d      (d),
      .q      (stage_q[k])
    );
  end

  // Output comes straight off the last flop: no path from in/enable to out.
  assign out = stage_q[STAGES-1];

endmodule

// File: tb/tb_pipeline_register.sv
// Directed bench for pipeline_register: history-queue model plus literal checks.
module tb_pipeline_register;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        flush = 1'b0;
  logic [7:0]  in8 = '0;
  logic [11:0] in_n = '0;
  logic [7:0]  d1_out, d3_out, d2_out, dn_out;
  logic [11:0] dw_out;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pipeline_register #(.N(8), .M(8), .STAGES(1)) u_d1 (
    .clk(clk), .reset(reset), .enable(enable),
`ifdef PIPELINE_REGISTER_FLUSH_EN
    .flush(flush),
`endif
    .in(in8), .out(d1_out));

  pipeline_register #(.N(8), .M(8), .STAGES(3)) u_d3 (
    .clk(clk), .reset(reset), .enable(enable),
`ifdef PIPELINE_REGISTER_FLUSH_EN
    .flush(flush),
`endif
    .in(in8), .out(d3_out));

  pipeline_register #(.N(8), .M(8), .STAGES(2)) u_d2 (
    .clk(clk), .reset(reset), .enable(enable),
`ifdef PIPELINE_REGISTER_FLUSH_EN
    .flush(flush),
`endif
    .in(in8), .out(d2_out));

  pipeline_register #(.N(8), .M(12), .STAGES(1)) u_dw (
    .clk(clk), .reset(reset), .enable(enable),
`ifdef PIPELINE_REGISTER_FLUSH_EN
    .flush(flush),
`endif
    .in(in8), .out(dw_out));

  pipeline_register #(.N(12), .M(8), .STAGES(1)) u_dn (
    .clk(clk), .reset(reset), .enable(enable),
`ifdef PIPELINE_REGISTER_FLUSH_EN
    .flush(flush),
`endif
    .in(in_n), .out(dn_out));

  // Model: every accepted value is appended to a history; a pipe of depth S
  // shows the value accepted S enabled edges ago, or 0 if too few exist.
  logic [15:0] h1[$], h3[$], h2[$], hw[$], hn[$];

  always @(posedge clk or posedge reset) begin
    if (reset || flush) begin
      h1.delete(); h3.delete(); h2.delete(); hw.delete(); hn.delete();
    end else if (enable) begin
      h1.push_back(16'(in8));
      h3.push_back(16'(in8));
      h2.push_back(16'(in8));
      hw.push_back(16'(in8));
      hn.push_back(16'(in_n % 12'd256));
    end
  end

  function automatic logic [15:0] mexp(input logic [15:0] q[$], input int s);
    if (q.size() >= s) return q[q.size() - s];
    return 16'h0;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_d1", 16'(d1_out), mexp(h1, 1));
    chk("model_d3", 16'(d3_out), mexp(h3, 3));
    chk("model_d2", 16'(d2_out), mexp(h2, 2));
    chk("model_dw", 16'(dw_out), mexp(hw, 1));
    chk("model_dn", 16'(dn_out), mexp(hn, 1));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    reset = 1'b1;
    #1;
    reset = 1'b0;
  endtask

  logic [7:0] r;
  logic [7:0] seq_in [6]  = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd0};
  logic [7:0] seq_out[6]  = '{8'd0, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4};
  logic [7:0] st_in  [8]  = '{8'd1, 8'd2, 8'd0, 8'd0, 8'd3, 8'd4, 8'd0, 8'd0};
  logic       st_en  [8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [7:0] st_out [8]  = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4};

  initial begin
    // reset state
    tick(); tick();
    chk("rst_d1", 16'(d1_out), 16'h0);
    chk("rst_dw", 16'(dw_out), 16'h0);
    reset = 1'b0;

    // async reset mid-cycle with enable high
    enable = 1'b1; in8 = 8'h77; in_n = 12'h123;
    tick();
    chk("pre_rst_d1", 16'(d1_out), 16'h77);
    chk("pre_rst_dn", 16'(dn_out), 16'h23);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_d1", 16'(d1_out), 16'h0);
    chk("async_rst_dn", 16'(dn_out), 16'h0);
    in8 = 8'hFF;
    tick(); chk("rst_hold1", 16'(d1_out), 16'h0);
    tick(); chk("rst_hold2", 16'(d1_out), 16'h0);
    reset = 1'b0;
    tick(); chk("rst_release", 16'(d1_out), 16'hFF);

    // capture
    in8 = 8'hA5;
    tick(); chk("cap_a5", 16'(d1_out), 16'hA5);
    for (int i = 0; i < 20; i++) begin
      r = 8'($urandom_range(0, 255));
      in8 = r;
      tick(); chk("cap_rand", 16'(d1_out), 16'(r));
    end

    // stall
    in8 = 8'h3C;
    tick(); chk("stall_load", 16'(d1_out), 16'h3C);
    enable = 1'b0; in8 = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("stall_hold", 16'(d1_out), 16'h3C);
    end
    enable = 1'b1;
    tick(); chk("stall_resume", 16'(d1_out), 16'hFF);

    // depth
    rst_pulse();
    for (int i = 0; i < 6; i++) begin
      in8 = seq_in[i];
      tick(); chk("depth", 16'(d3_out), 16'(seq_out[i]));
    end

    // depth with a stall mid-stream; X on in while stalled
    rst_pulse();
    for (int i = 0; i < 8; i++) begin
      enable = st_en[i];
      in8 = st_en[i] ? st_in[i] : 8'hxx;
      tick(); chk("depth_stall", 16'(d3_out), 16'(st_out[i]));
    end
    enable = 1'b1;

    // width adaptation
    in8 = 8'hF0; in_n = 12'hABC;
    tick();
    chk("widen", 16'(dw_out), 16'h0F0);
    chk("narrow", 16'(dn_out), 16'h0BC);

`ifdef PIPELINE_REGISTER_FLUSH_EN
    rst_pulse();
    in8 = 8'd5; tick();
    in8 = 8'd6; tick();
    chk("fl_fill", 16'(d2_out), 16'd5);
    flush = 1'b1; enable = 1'b0;
    tick(); chk("fl_clear", 16'(d2_out), 16'd0);
    flush = 1'b0;
    tick(); chk("fl_idle", 16'(d2_out), 16'd0);
    enable = 1'b1; in8 = 8'd7;
    tick(); chk("fl_stage0", 16'(d2_out), 16'd0);
    in8 = 8'd9;
    tick(); chk("fl_refill", 16'(d2_out), 16'd7);
    #1 reset = 1'b1; flush = 1'b1;
    #1 chk("fl_rst_both", 16'(d2_out), 16'd0);
    tick();
    reset = 1'b0; flush = 1'b0;
`endif

    tick(); tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
